// File: rtl/traffic_request_arbiter_if.sv
// Request handshake between the traffic request arbiter and the light controller.
// The arbiter (master) offers one coded request; the light controller (slave)
// answers with req_ready in the cycle it takes it.
interface traffic_request_arbiter_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_code;

    modport master (
        output req_valid,
        output req_code,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_code,
        output req_ready
    );
endinterface

// File: rtl/traffic_request_arbiter.sv
// Traffic request arbiter: synchronises and debounces the four service inputs,
// keeps them as pending requests and offers the most urgent one to the light
// controller, with a cooldown between services and a left-turn starvation guard.
// Channel order everywhere: 0 emergency, 1 power, 2 pedestrian, 3 left turn.
module traffic_request_arbiter #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int COOLDOWN_TICKS = 8,
    parameter int MAX_SKIPS      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        emergency_in,
    input  logic                        power_in,
    input  logic                        ped_in,
    input  logic                        left_in,
    traffic_request_arbiter_if.master   req,
    output logic [3:0]                  pending,
    output logic                        ped_wait_lamp,
    output logic [3:0]                  skip_cnt
);

    typedef enum logic [1:0] {IDLE, OFFER, COOLDOWN} state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_TICKS - 1);

    logic [3:0]  raw;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  deb;
    logic [7:0]  deb_cnt [4];
    logic [3:0]  deb_done;
    logic [3:0]  rise;
    logic [3:0]  pend;
    logic [3:0]  pend_next;
    logic [3:0]  skip;
    state_t      state;
    state_t      state_n;
    logic [1:0]  code;
    logic [1:0]  code_n;
    logic [15:0] cool_cnt;
    logic [15:0] cool_n;
    logic        offer_valid;
    logic        accept;
    logic        withdrawn;

    assign raw       = {left_in, ped_in, power_in, emergency_in};
    assign rise      = deb_done & sync2;
    assign accept    = offer_valid & req.req_ready;
    // A power offer whose level has dropped must not be accepted any more.
    assign withdrawn = (code == 2'd1) && !pend[1];

    // Highest-priority pending request; a starved left turn overtakes pedestrian.
    function automatic logic [1:0] best_code(input logic [3:0] p, input logic [3:0] s);
        if (p[0])                         return 2'd0;
        else if (p[1])                    return 2'd1;
        else if (p[3] && (s >= 4'(MAX_SKIPS))) return 2'd3;
        else if (p[2])                    return 2'd2;
        else                              return 2'd3;
    endfunction

    // Two-flop synchroniser on every raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Flags the tick on which a channel's new level has been held long enough.
    always_comb begin
        deb_done = '0;
        for (int i = 0; i < 4; i++) begin
            deb_done[i] = tick && (sync2[i] != deb[i]) && (deb_cnt[i] == DEB_LAST);
        end
    end

    // Per-channel debounce counters and accepted levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (tick) begin
                    if (sync2[i] != deb[i]) begin
                        if (deb_done[i]) begin
                            deb[i]     <= sync2[i];
                            deb_cnt[i] <= '0;
                        end else begin
                            deb_cnt[i] <= deb_cnt[i] + 8'd1;
                        end
                    end else begin
                        deb_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Sticky bits set on a debounced rise and cleared on acceptance; power follows its level.
    always_comb begin
        pend_next    = pend;
        pend_next[1] = deb_done[1] ? sync2[1] : deb[1];
        if (rise[0])                          pend_next[0] = 1'b1;
        else if (accept && (code == 2'd0))    pend_next[0] = 1'b0;
        if (rise[2])                          pend_next[2] = 1'b1;
        else if (accept && (code == 2'd2))    pend_next[2] = 1'b0;
        if (rise[3])                          pend_next[3] = 1'b1;
        else if (accept && (code == 2'd3))    pend_next[3] = 1'b0;
    end

    // Pending register and the count of pedestrian grants that bypassed a left turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            skip <= '0;
        end else begin
            pend <= pend_next;
            if (!pend[3])
                skip <= '0;
            else if (accept && (code == 2'd3))
                skip <= '0;
            else if (accept && (code == 2'd2) && (skip != 4'd15))
                skip <= skip + 4'd1;
        end
    end

    // FSM state, offered code and cooldown counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code     <= 2'd0;
            cool_cnt <= '0;
        end else begin
            state    <= state_n;
            code     <= code_n;
            cool_cnt <= cool_n;
        end
    end

    // Next-state logic: offer, hold, preempt, withdraw and cooldown.
    always_comb begin
        state_n = state;
        code_n  = code;
        cool_n  = cool_cnt;
        case (state)
            IDLE: begin
                if (|pend) begin
                    state_n = OFFER;
                    code_n  = best_code(pend, skip);
                end
            end
            OFFER: begin
                if (accept) begin
                    if (COOLDOWN_TICKS == 0) begin
                        if (|pend_next) code_n = best_code(pend_next, skip);
                        else            state_n = IDLE;
                    end else begin
                        state_n = COOLDOWN;
                        cool_n  = '0;
                    end
                end else if (pend[0] && (code != 2'd0)) begin
                    code_n = 2'd0;
                end else if (withdrawn) begin
                    if (|pend) code_n = best_code(pend, skip);
                    else       state_n = IDLE;
                end
            end
            COOLDOWN: begin
                if (pend[0]) begin
                    state_n = OFFER;
                    code_n  = 2'd0;
                end else if (tick) begin
                    if (({1'b0, cool_cnt} + 17'd1) >= 17'(COOLDOWN_TICKS))
                        state_n = IDLE;
                    else
                        cool_n = cool_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs derived from the current state.
    always_comb begin
        offer_valid  = (state == OFFER) && !withdrawn;
        req.req_valid = offer_valid;
        req.req_code  = code;
    end

    assign pending       = pend;
    assign ped_wait_lamp = pend[2];
    assign skip_cnt      = skip;

endmodule

// File: tb/tb_traffic_request_arbiter.sv
// Bench for the traffic request arbiter: a table of held-input steps with
// hand-derived expectations, an asynchronous reset during an offer, then a
// randomized run compared every cycle against a behavioural model.
module tb_traffic_request_arbiter;

    localparam int DEB  = 4;
    localparam int COOL = 8;
    localparam int MAXS = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic tick;
    logic emergency_in;
    logic power_in;
    logic ped_in;
    logic left_in;
    logic ready;
    logic [3:0] pending;
    logic ped_wait_lamp;
    logic [3:0] skip_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    traffic_request_arbiter_if req_if ();
    assign req_if.req_ready = ready;

    traffic_request_arbiter #(
        .DEBOUNCE_TICKS(DEB),
        .COOLDOWN_TICKS(COOL),
        .MAX_SKIPS(MAXS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .emergency_in(emergency_in),
        .power_in(power_in),
        .ped_in(ped_in),
        .left_in(left_in),
        .req(req_if.master),
        .pending(pending),
        .ped_wait_lamp(ped_wait_lamp),
        .skip_cnt(skip_cnt)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        logic       emerg;
        logic       power;
        logic       ped;
        logic       left;
        logic       rdy;
        int         cycles;
        logic       exp_valid;
        logic [1:0] exp_code;
        logic [3:0] exp_pend;
        logic [3:0] exp_skip;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: synchroniser stages, accepted levels and how
    // long each has disagreed, request set, bypass count and offer mode
    // (0 quiet, 1 offering, 2 cooling down).
    bit [3:0] m_s1, m_s2, m_lvl, m_pend;
    int       m_run [4];
    int       m_skip, m_mode, m_code, m_cool;

    function automatic int bestOf(input bit [3:0] p, input int s);
        if (p[0]) return 0;
        if (p[1]) return 1;
        if (p[3] && s >= MAXS) return 3;
        if (p[2]) return 2;
        return 3;
    endfunction

    function automatic bit modelValid();
        return (m_mode == 1) && !((m_code == 1) && !m_pend[1]);
    endfunction

    task automatic modelReset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0;
        for (int c = 0; c < 4; c++) m_run[c] = 0;
        m_skip = 0; m_mode = 0; m_code = 0; m_cool = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit [3:0] raw;
        bit [3:0] lvl_n;
        bit [3:0] rise;
        bit [3:0] pend_n;
        int       run_n [4];
        bit       acc;
        int       skip_n, mode_n, code_n, cool_n;
        raw   = {left_in, ped_in, power_in, emergency_in};
        acc   = modelValid() && ready;
        lvl_n = m_lvl;
        rise  = '0;
        for (int c = 0; c < 4; c++) begin
            run_n[c] = m_run[c];
            if (tick) begin
                if (m_s2[c] != m_lvl[c]) begin
                    if (m_run[c] + 1 == DEB) begin
                        lvl_n[c] = m_s2[c];
                        run_n[c] = 0;
                        rise[c]  = m_s2[c];
                    end else begin
                        run_n[c] = m_run[c] + 1;
                    end
                end else begin
                    run_n[c] = 0;
                end
            end
        end
        pend_n = m_pend;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) pend_n[c] = lvl_n[1];
            else if (rise[c]) pend_n[c] = 1'b1;
            else if (acc && m_code == c) pend_n[c] = 1'b0;
        end
        skip_n = m_skip;
        if (!m_pend[3]) skip_n = 0;
        else if (acc && m_code == 3) skip_n = 0;
        else if (acc && m_code == 2) skip_n = (m_skip >= 15) ? 15 : m_skip + 1;
        mode_n = m_mode; code_n = m_code; cool_n = m_cool;
        if (m_mode == 0) begin
            if (m_pend != 0) begin mode_n = 1; code_n = bestOf(m_pend, m_skip); end
        end else if (m_mode == 1) begin
            if (acc) begin
                if (COOL == 0) begin
                    if (pend_n != 0) code_n = bestOf(pend_n, m_skip);
                    else mode_n = 0;
                end else begin
                    mode_n = 2; cool_n = 0;
                end
            end else if (m_pend[0] && m_code != 0) begin
                code_n = 0;
            end else if (m_code == 1 && !m_pend[1]) begin
                if (m_pend == 0) mode_n = 0;
                else code_n = bestOf(m_pend, m_skip);
            end
        end else begin
            if (m_pend[0]) begin mode_n = 1; code_n = 0; end
            else if (tick) begin
                if (m_cool + 1 >= COOL) mode_n = 0;
                else cool_n = m_cool + 1;
            end
        end
        m_s2 = m_s1; m_s1 = raw; m_lvl = lvl_n; m_pend = pend_n;
        for (int c = 0; c < 4; c++) m_run[c] = run_n[c];
        m_skip = skip_n; m_mode = mode_n; m_code = code_n; m_cool = cool_n;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock with inputs held; outputs are sampled 1 unit after the edge.
    task automatic stepCycle();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        emergency_in = 0; power_in = 0; ped_in = 0; left_in = 0; ready = 0; tick = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic addVec(input logic e, input logic p, input logic pd, input logic l,
                          input logic r, input int n, input logic v, input logic [1:0] c,
                          input logic [3:0] pe, input logic [3:0] s);
        vec_t t;
        t.emerg = e; t.power = p; t.ped = pd; t.left = l; t.rdy = r; t.cycles = n;
        t.exp_valid = v; t.exp_code = c; t.exp_pend = pe; t.exp_skip = s;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        emergency_in = v.emerg; power_in = v.power; ped_in = v.ped;
        left_in = v.left; ready = v.rdy; tick = 1'b1;
        repeat (v.cycles) stepCycle();
        checkOutput($sformatf("row%0d.valid", idx), int'(req_if.req_valid), int'(v.exp_valid));
        if (v.exp_valid)
            checkOutput($sformatf("row%0d.code", idx), int'(req_if.req_code), int'(v.exp_code));
        checkOutput($sformatf("row%0d.pending", idx), int'(pending), int'(v.exp_pend));
        checkOutput($sformatf("row%0d.lamp", idx), int'(ped_wait_lamp), int'(v.exp_pend[2]));
        checkOutput($sformatf("row%0d.skip", idx), int'(skip_cnt), int'(v.exp_skip));
    endtask

    initial begin
        logic [11:0] act_vec;
        logic [11:0] exp_vec;
        bit          ev;

        // Inputs: emerg, power, ped, left, ready, cycles | valid, code, pending{L,P,Pw,E}, skip
        addVec(0,0,1,0,0, 3,  0,0,4'b0000,0);  // 3-cycle glitch is filtered
        addVec(0,0,0,0,0, 6,  0,0,4'b0000,0);
        addVec(0,0,1,0,0, 6,  0,0,4'b0100,0);  // pedestrian latched after 2 sync + 4 ticks
        addVec(0,0,0,0,0, 1,  1,2,4'b0100,0);  // offered the following cycle
        addVec(0,0,0,0,0, 10, 1,2,4'b0100,0);  // held while not ready
        addVec(0,0,0,0,1, 1,  0,0,4'b0000,0);  // accepted
        addVec(0,0,0,0,0, 9,  0,0,4'b0000,0);
        addVec(0,1,0,0,0, 6,  0,0,4'b0010,0);  // power level
        addVec(0,1,0,0,0, 1,  1,1,4'b0010,0);
        addVec(0,1,0,0,1, 1,  0,0,4'b0010,0);  // accept keeps power pending
        addVec(0,1,0,0,0, 7,  0,0,4'b0010,0);
        addVec(0,1,0,0,0, 1,  0,0,4'b0010,0);  // 8th cooldown tick
        addVec(0,1,0,0,0, 1,  1,1,4'b0010,0);  // re-offered
        addVec(0,0,0,0,0, 5,  1,1,4'b0010,0);
        addVec(0,0,0,0,0, 1,  0,0,4'b0000,0);  // level drop withdraws offer
        addVec(0,0,0,0,0, 3,  0,0,4'b0000,0);
        addVec(0,0,0,1,0, 6,  0,0,4'b1000,0);  // left turn
        addVec(0,0,0,1,0, 1,  1,3,4'b1000,0);
        addVec(1,0,0,1,0, 6,  1,3,4'b1001,0);
        addVec(1,0,0,1,0, 1,  1,0,4'b1001,0);  // emergency preempts
        addVec(1,0,0,1,1, 1,  0,0,4'b1000,0);
        addVec(1,0,0,1,0, 8,  0,0,4'b1000,0);
        addVec(1,0,0,1,0, 1,  1,3,4'b1000,0);  // left after cooldown
        addVec(1,0,0,1,1, 1,  0,0,4'b0000,0);
        addVec(0,0,0,0,0, 10, 0,0,4'b0000,0);
        addVec(0,0,1,1,0, 6,  0,0,4'b1100,0);  // starvation guard
        addVec(0,0,0,1,0, 1,  1,2,4'b1100,0);
        addVec(0,0,0,1,0, 5,  1,2,4'b1100,0);
        addVec(0,0,1,1,1, 1,  0,0,4'b1000,1);
        addVec(0,0,1,1,0, 8,  0,0,4'b1100,1);
        addVec(0,0,1,1,0, 1,  1,2,4'b1100,1);
        addVec(0,0,0,1,0, 6,  1,2,4'b1100,1);
        addVec(0,0,1,1,1, 1,  0,0,4'b1000,2);
        addVec(0,0,1,1,0, 8,  0,0,4'b1100,2);
        addVec(0,0,1,1,0, 1,  1,3,4'b1100,2);  // left now outranks pedestrian
        addVec(0,0,1,1,1, 1,  0,0,4'b0100,0);
        addVec(0,0,0,0,0, 9,  1,2,4'b0100,0);
        addVec(0,0,0,0,1, 1,  0,0,4'b0000,0);
        addVec(0,0,0,0,0, 10, 0,0,4'b0000,0);

        rst_n = 1'b0;
        emergency_in = 0; power_in = 0; ped_in = 0; left_in = 0; ready = 0; tick = 1;
        #12;
        checkOutput("reset.valid",   int'(req_if.req_valid), 0);
        checkOutput("reset.pending", int'(pending), 0);
        checkOutput("reset.lamp",    int'(ped_wait_lamp), 0);
        checkOutput("reset.skip",    int'(skip_cnt), 0);
        doReset();

        $display("[TB] table-driven vectors");
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        $display("[TB] asynchronous reset during an offer");
        left_in = 1; ped_in = 1; ready = 0;
        repeat (7) stepCycle();
        checkOutput("preReset.valid", int'(req_if.req_valid), 1);
        checkOutput("preReset.pending", int'(pending), 4'b1100);
        rst_n = 1'b0;
        #2;
        checkOutput("asyncReset.valid",   int'(req_if.req_valid), 0);
        checkOutput("asyncReset.pending", int'(pending), 0);
        checkOutput("asyncReset.skip",    int'(skip_cnt), 0);
        doReset();

        $display("[TB] randomized run against model");
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) emergency_in = ~emergency_in;
            if ($urandom_range(0, 15) == 0) power_in = ~power_in;
            if ($urandom_range(0, 11) == 0) ped_in = ~ped_in;
            if ($urandom_range(0, 11) == 0) left_in = ~left_in;
            ready = ($urandom_range(0, 3) == 0);
            tick  = ($urandom_range(0, 1) == 0);
            stepCycle();
            ev      = modelValid();
            exp_vec = {ev, ev ? 2'(m_code) : 2'b00, m_pend, m_pend[2], 4'(m_skip)};
            act_vec = {req_if.req_valid, req_if.req_valid ? req_if.req_code : 2'b00,
                       pending, ped_wait_lamp, skip_cnt};
            checkOutput($sformatf("random.cycle%0d", k), int'(act_vec), int'(exp_vec));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
